// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared writeback widths and the buffered writeback entry type
package rf_wb_arbiter_pkg;

  localparam int DEF_DATAWIDTH = 64;
  localparam int DEF_RFDEPTH   = 4;
  localparam int DEF_AW        = $clog2(DEF_RFDEPTH);
  localparam int DEF_QDEPTH    = 2;

  // One pending register-file write; live=0 means a younger write superseded it.
  typedef struct packed {
    logic                     live;
    logic [DEF_AW-1:0]        waddr;
    logic [DEF_DATAWIDTH-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// rtl/rf_wb_arbiter_wb_fifo.sv - load-result circular buffer with per-entry live bits and kill-by-address
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int AW        = DEF_AW,
  parameter int QDEPTH    = DEF_QDEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  input  logic [AW-1:0]                push_waddr,
  input  logic [DATAWIDTH-1:0]         push_wdata,
  input  logic                         kill_valid,
  input  logic [AW-1:0]                kill_waddr,
  input  logic                         pop,
  output logic                         head_valid,
  output logic                         head_live,
  output logic [AW-1:0]                head_waddr,
  output logic [DATAWIDTH-1:0]         head_wdata,
  output logic                         full,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  logic [QDEPTH-1:0]    occ_q, occ_d;
  logic [QDEPTH-1:0]    live_q, live_d;
  logic [AW-1:0]        addr_q [QDEPTH];
  logic [AW-1:0]        addr_d [QDEPTH];
  logic [DATAWIDTH-1:0] data_q [QDEPTH];
  logic [DATAWIDTH-1:0] data_d [QDEPTH];
  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        count_q, count_d;

  assign head_valid = (count_q != '0);
  assign head_waddr = addr_q[rd_q];
  assign head_wdata = data_q[rd_q];
  // Live bit as seen after this cycle's kill, so a just-killed head is discarded.
  assign head_live  = live_q[rd_q] & ~(kill_valid && (addr_q[rd_q] == kill_waddr));
  assign full       = (count_q == CW'(QDEPTH));
  assign count      = count_q;

  always_comb begin
    occ_d  = occ_q;
    live_d = live_q;
    addr_d = addr_q;
    data_d = data_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (kill_valid && occ_q[i] && (addr_q[i] == kill_waddr)) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      occ_d[rd_q] = 1'b0;
    end
    // A load arriving with the ALU write is older, so it is stored already dead.
    if (push_valid) begin
      occ_d[wr_q]  = 1'b1;
      live_d[wr_q] = ~(kill_valid && (push_waddr == kill_waddr));
      addr_d[wr_q] = push_waddr;
      data_d[wr_q] = push_wdata;
    end
    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(push_valid);
    count_d = count_q + CW'(push_valid) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q   <= '0;
      live_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      occ_q   <= occ_d;
      live_q  <= live_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - merges ALU and load writebacks onto the single register-file write port
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int RFDEPTH   = DEF_RFDEPTH,
  parameter int QDEPTH    = DEF_QDEPTH,
  parameter int AW        = $clog2(RFDEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [AW-1:0]                alu_waddr,
  input  logic [DATAWIDTH-1:0]         alu_wdata,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [AW-1:0]                mem_waddr,
  input  logic [DATAWIDTH-1:0]         mem_wdata,
  output logic                         wen,
  output logic [AW-1:0]                waddr,
  output logic [DATAWIDTH-1:0]         wdata,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  output logic                         busy
);

  logic                 fifo_full;
  logic                 head_valid;
  logic                 head_live;
  logic [AW-1:0]        head_waddr;
  logic [DATAWIDTH-1:0] head_wdata;
  logic                 push;
  logic                 pop;

  logic                 wen_q, wen_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;

  assign mem_ready = ~fifo_full;
  assign push      = mem_valid & mem_ready;
  // Dead heads drain even under ALU traffic; live heads wait for an idle ALU slot.
  assign pop       = head_valid & (~head_live | ~alu_valid);

  wb_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .AW        (AW),
    .QDEPTH    (QDEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push),
    .push_waddr (mem_waddr),
    .push_wdata (mem_wdata),
    .kill_valid (alu_valid),
    .kill_waddr (alu_waddr),
    .pop        (pop),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_waddr (head_waddr),
    .head_wdata (head_wdata),
    .full       (fifo_full),
    .count      (q_count)
  );

  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_valid) begin
      wen_d   = 1'b1;
      waddr_d = alu_waddr;
      wdata_d = alu_wdata;
    end else if (head_valid && head_live) begin
      wen_d   = 1'b1;
      waddr_d = head_waddr;
      wdata_d = head_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = (q_count != '0) | wen_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for the register-file writeback arbiter
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int QD = DEF_QDEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [1:0]  alu_waddr = '0;
  logic [63:0] alu_wdata = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [1:0]  mem_waddr = '0;
  logic [63:0] mem_wdata = '0;
  logic        wen;
  logic [1:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  q_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        av;
    logic [1:0]  aa;
    logic [63:0] ad;
    logic        mv;
    logic [1:0]  ma;
    logic [63:0] md;
    logic        ew;
    logic [1:0]  ea;
    logic [63:0] ed;
    logic [1:0]  eq;
    logic        er;
  } vec_t;

  vec_t      vecs[28];
  wb_entry_t mq[$];
  wb_entry_t sbq[$];

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .q_count   (q_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int av, input int aa, input logic [31:0] ad,
                              input int mv, input int ma, input logic [31:0] md,
                              input int ew, input int ea, input logic [31:0] ed,
                              input int eq, input int er);
    vec_t v;
    v.av = av[0]; v.aa = aa[1:0]; v.ad = {32'd0, ad};
    v.mv = mv[0]; v.ma = ma[1:0]; v.md = {32'd0, md};
    v.ew = ew[0]; v.ea = ea[1:0]; v.ed = {32'd0, ed};
    v.eq = eq[1:0]; v.er = er[0];
    return v;
  endfunction

  task automatic drive(input logic av, input logic [1:0] aa, input logic [63:0] ad,
                       input logic mv, input logic [1:0] ma, input logic [63:0] md);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour for one cycle: predicts the RF write and updates the load queue.
  task automatic model_step(input logic av, input logic [1:0] aa, input logic [63:0] ad,
                            input logic mv, input logic [1:0] ma, input logic [63:0] md);
    logic      rdy;
    wb_entry_t e;
    rdy = (mq.size() != QD);
    chk("rand_mem_ready", {63'd0, mem_ready}, {63'd0, rdy});
    if (av) begin
      foreach (mq[i]) if (mq[i].waddr == aa) mq[i].live = 1'b0;
    end
    if (mq.size() > 0) begin
      if (!mq[0].live) begin
        e = mq.pop_front();
      end else if (!av) begin
        e = mq.pop_front();
        sbq.push_back(e);
      end
    end
    if (av) begin
      e.live = 1'b1; e.waddr = aa; e.wdata = ad;
      sbq.push_back(e);
    end
    if (mv && rdy) begin
      e.live = !(av && (ma == aa)); e.waddr = ma; e.wdata = md;
      mq.push_back(e);
    end
  endtask

  task automatic rand_cycle(input logic av, input logic [1:0] aa, input logic [63:0] ad,
                            input logic mv, input logic [1:0] ma, input logic [63:0] md);
    wb_entry_t e;
    drive(av, aa, ad, mv, ma, md);
    model_step(av, aa, ad, mv, ma, md);
    tick();
    if (wen) begin
      if (sbq.size() == 0) begin
        chk("rand_unexpected_wen", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("rand_waddr", {62'd0, waddr}, {62'd0, e.waddr});
        chk("rand_wdata", wdata, e.wdata);
      end
    end
    chk("rand_q_count", {62'd0, q_count}, 64'(mq.size()));
  endtask

  initial begin
    //        av aa ad       mv ma md       ew ea ed       eq er
    vecs[0]  = mk(1, 2, 'hDEAD,  0, 0, 0,      1, 2, 'hDEAD,  0, 1);
    vecs[1]  = mk(0, 0, 0,       0, 0, 0,      0, 2, 'hDEAD,  0, 1);
    vecs[2]  = mk(1, 0, 1,       1, 1, 'h11,   1, 0, 1,       1, 1);
    vecs[3]  = mk(1, 0, 2,       1, 3, 'h33,   1, 0, 2,       2, 0);
    vecs[4]  = mk(1, 0, 3,       1, 2, 'h99,   1, 0, 3,       2, 0);
    vecs[5]  = mk(0, 0, 0,       0, 0, 0,      1, 1, 'h11,    1, 1);
    vecs[6]  = mk(0, 0, 0,       0, 0, 0,      1, 3, 'h33,    0, 1);
    vecs[7]  = mk(0, 0, 0,       0, 0, 0,      0, 3, 'h33,    0, 1);
    vecs[8]  = mk(0, 0, 0,       1, 2, 'hAAAA, 0, 3, 'h33,    1, 1);
    vecs[9]  = mk(1, 2, 'hBBBB,  0, 0, 0,      1, 2, 'hBBBB,  0, 1);
    vecs[10] = mk(0, 0, 0,       0, 0, 0,      0, 2, 'hBBBB,  0, 1);
    vecs[11] = mk(1, 1, 'h100,   1, 2, 'hA1,   1, 1, 'h100,   1, 1);
    vecs[12] = mk(1, 1, 'h101,   1, 3, 'hA3,   1, 1, 'h101,   2, 0);
    vecs[13] = mk(1, 3, 'h102,   0, 0, 0,      1, 3, 'h102,   2, 0);
    vecs[14] = mk(0, 0, 0,       0, 0, 0,      1, 2, 'hA1,    1, 1);
    vecs[15] = mk(0, 0, 0,       0, 0, 0,      0, 2, 'hA1,    0, 1);
    vecs[16] = mk(1, 0, 6,       1, 0, 5,      1, 0, 6,       1, 1);
    vecs[17] = mk(0, 0, 0,       0, 0, 0,      0, 0, 6,       0, 1);
    vecs[18] = mk(1, 1, 7,       1, 2, 8,      1, 1, 7,       1, 1);
    vecs[19] = mk(0, 0, 0,       0, 0, 0,      1, 2, 8,       0, 1);
    vecs[20] = mk(0, 0, 0,       0, 0, 0,      0, 2, 8,       0, 1);
    vecs[21] = mk(0, 0, 0,       1, 1, 'hC1,   0, 2, 8,       1, 1);
    vecs[22] = mk(0, 0, 0,       1, 2, 'hC2,   1, 1, 'hC1,    1, 1);
    vecs[23] = mk(0, 0, 0,       0, 0, 0,      1, 2, 'hC2,    0, 1);
    vecs[24] = mk(0, 0, 0,       1, 3, 'hD3,   0, 2, 'hC2,    1, 1);
    vecs[25] = mk(1, 3, 'hE3,    1, 0, 'hD0,   1, 3, 'hE3,    1, 1);
    vecs[26] = mk(0, 0, 0,       0, 0, 0,      1, 0, 'hD0,    0, 1);
    vecs[27] = mk(0, 0, 0,       0, 0, 0,      0, 0, 'hD0,    0, 1);

    // Reset held with an ALU request pending must keep the port quiet.
    drive(1'b1, 2'd3, 64'h42, 1'b1, 2'd1, 64'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_wen",       {63'd0, wen},       64'd0);
      chk("reset_q_count",   {62'd0, q_count},   64'd0);
      chk("reset_mem_ready", {63'd0, mem_ready}, 64'd1);
      chk("reset_busy",      {63'd0, busy},      64'd0);
      chk("reset_waddr",     {62'd0, waddr},     64'd0);
      chk("reset_wdata",     wdata,              64'd0);
    end
    mem_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("release_wen",   {63'd0, wen},   64'd1);
    chk("release_waddr", {62'd0, waddr}, 64'd3);
    chk("release_wdata", wdata,          64'h42);

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
      tick();
      chk($sformatf("vec%0d_wen", i),       {63'd0, wen},       {63'd0, vecs[i].ew});
      chk($sformatf("vec%0d_waddr", i),     {62'd0, waddr},     {62'd0, vecs[i].ea});
      chk($sformatf("vec%0d_wdata", i),     wdata,              vecs[i].ed);
      chk($sformatf("vec%0d_q_count", i),   {62'd0, q_count},   {62'd0, vecs[i].eq});
      chk($sformatf("vec%0d_mem_ready", i), {63'd0, mem_ready}, {63'd0, vecs[i].er});
      chk($sformatf("vec%0d_busy", i),      {63'd0, busy},
          {63'd0, (vecs[i].eq != 2'd0) || vecs[i].ew});
    end

    // Asynchronous reset with a full queue and a write on the port.
    drive(1'b1, 2'd1, 64'hF1, 1'b1, 2'd0, 64'hE0);
    tick();
    drive(1'b1, 2'd2, 64'hF2, 1'b1, 2'd3, 64'hE3);
    tick();
    chk("midrst_pre_q_count", {62'd0, q_count}, 64'd2);
    chk("midrst_pre_wen",     {63'd0, wen},     64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_wen",       {63'd0, wen},       64'd0);
    chk("midrst_q_count",   {62'd0, q_count},   64'd0);
    chk("midrst_mem_ready", {63'd0, mem_ready}, 64'd1);
    chk("midrst_busy",      {63'd0, busy},      64'd0);
    drive(1'b0, 2'd0, 64'd0, 1'b0, 2'd0, 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_wen",     {63'd0, wen},     64'd0);
      chk("postrst_q_count", {62'd0, q_count}, 64'd0);
    end

    // Random traffic against the reference queue, with narrow addresses to force collisions.
    for (int i = 0; i < 400; i++) begin
      rand_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {32'd0, $urandom},
                 1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), {32'd0, $urandom});
    end
    for (int i = 0; i < 4; i++) begin
      rand_cycle(1'b0, 2'd0, 64'd0, 1'b0, 2'd0, 64'd0);
    end
    chk("rand_scoreboard_drained", 64'(sbq.size()), 64'd0);
    chk("rand_final_busy", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
